// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/execute controller for the 16-bit CPU.
// Fetches instructions byte-wise over an 8-bit memory port, gathers operands,
// strobes the decoder/datapath for one cycle and performs word stores.
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   run               0 = stop at the next instruction boundary
//   mem_req/we/space  transfer request, 1=write, 0=program 1=data RAM
//   mem_addr/wdata    byte address and write byte
//   mem_rdata/ack     read byte and transfer-complete handshake
//   inst/data/operand instruction register, inline byte, RAM operand word
//   dec_en/exec       decoder enable and one-cycle execute strobe
//   acc/acc_zero      accumulator value and zero flag (store, if tests)
//   cond_flag         "else" condition flag (if tests)
//   pc, halted        next program byte address, idle at a boundary
module cpu_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_space,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] inst,
    output logic [7:0]  data,
    output logic [15:0] operand,
    output logic        dec_en,
    output logic        exec,
    input  logic [15:0] acc,
    input  logic        acc_zero,
    input  logic        cond_flag,
    output logic [15:0] pc,
    output logic        halted
);

    typedef enum logic [2:0] {
        FETCH_HI, FETCH_LO, FETCH_DATA, RAM_HI,
        RAM_LO, EXEC, STORE_HI, STORE_LO
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] opnd_q, opnd_d;
    logic [15:0] wbuf_q, wbuf_d;
    logic        skip_q, skip_d;
    logic        hold_q, hold_d;
    logic        exec_q, exec_d;

    logic        req_c, we_c, space_c;
    logic [15:0] addr_c;
    logic [7:0]  wdata_c;

    logic [4:0]  op;
    logic [2:0]  src;
    logic        is_alu, is_store, is_br, is_if, test_ok;
    logic [15:0] ram_addr;
    logic [15:0] ram_addr_p1;

    assign op          = inst_q[15:11];
    assign src         = inst_q[10:8];
    assign is_alu      = (op[4:2] == 3'b100);
    assign is_store    = (op == 5'b10010);
    assign is_br       = (op == 5'b11000);
    assign is_if       = (op == 5'b11110);
    assign ram_addr    = {8'h00, inst_q[7:0]};
    assign ram_addr_p1 = ram_addr + 16'd1;

    // Unlisted test fields behave as nop: treated as true, never skip.
    always_comb begin
        test_ok = 1'b1;
        case (inst_q[10:0])
            11'h000: test_ok = acc_zero;
            11'h001: test_ok = ~acc_zero;
            11'h010: test_ok = cond_flag;
            11'h011: test_ok = ~cond_flag;
            default: test_ok = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        data_d  = data_q;
        opnd_d  = opnd_q;
        wbuf_d  = wbuf_q;
        skip_d  = skip_q;
        hold_d  = hold_q;
        req_c   = 1'b0;
        we_c    = 1'b0;
        space_c = 1'b0;
        addr_c  = pc_q;
        wdata_c = 8'h00;
        case (state_q)
            FETCH_HI: begin
                // hold_q keeps an already-raised request alive if run drops
                req_c = run | hold_q;
                if (req_c) begin
                    if (mem_ack) begin
                        inst_d[15:8] = mem_rdata;
                        pc_d         = pc_q + 16'd1;
                        hold_d       = 1'b0;
                        state_d      = FETCH_LO;
                    end else begin
                        hold_d = 1'b1;
                    end
                end
            end
            FETCH_LO: begin
                req_c = 1'b1;
                if (mem_ack) begin
                    inst_d[7:0] = mem_rdata;
                    pc_d        = pc_q + 16'd1;
                    if (is_alu && src[2:1] == 2'b01)
                        state_d = FETCH_DATA;
                    else if (is_alu && src[2] && !skip_q)
                        state_d = RAM_HI;
                    else
                        state_d = EXEC;
                end
            end
            FETCH_DATA: begin
                req_c = 1'b1;
                if (mem_ack) begin
                    data_d  = mem_rdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = EXEC;
                end
            end
            RAM_HI: begin
                req_c   = 1'b1;
                space_c = 1'b1;
                addr_c  = ram_addr;
                if (mem_ack) begin
                    opnd_d[15:8] = mem_rdata;
                    state_d      = RAM_LO;
                end
            end
            RAM_LO: begin
                req_c   = 1'b1;
                space_c = 1'b1;
                addr_c  = ram_addr_p1;
                if (mem_ack) begin
                    opnd_d[7:0] = mem_rdata;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH_HI;
                if (skip_q) begin
                    skip_d = 1'b0;
                end else begin
                    // pc already points past this instruction and its data
                    if (is_br)
                        pc_d = pc_q + {{5{inst_q[10]}}, inst_q[10:0]};
                    if (is_if && !test_ok)
                        skip_d = 1'b1;
                    if (is_store) begin
                        wbuf_d  = acc;
                        state_d = STORE_HI;
                    end
                end
            end
            STORE_HI: begin
                req_c   = 1'b1;
                we_c    = 1'b1;
                space_c = 1'b1;
                addr_c  = ram_addr;
                wdata_c = wbuf_q[15:8];
                if (mem_ack)
                    state_d = STORE_LO;
            end
            STORE_LO: begin
                req_c   = 1'b1;
                we_c    = 1'b1;
                space_c = 1'b1;
                addr_c  = ram_addr_p1;
                wdata_c = wbuf_q[7:0];
                if (mem_ack)
                    state_d = FETCH_HI;
            end
            default: state_d = FETCH_HI;
        endcase
        exec_d = (state_d == EXEC) && !skip_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH_HI;
            pc_q    <= RESET_PC;
            inst_q  <= 16'h0000;
            data_q  <= 8'h00;
            opnd_q  <= 16'h0000;
            wbuf_q  <= 16'h0000;
            skip_q  <= 1'b0;
            hold_q  <= 1'b0;
            exec_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            data_q  <= data_d;
            opnd_q  <= opnd_d;
            wbuf_q  <= wbuf_d;
            skip_q  <= skip_d;
            hold_q  <= hold_d;
            exec_q  <= exec_d;
        end
    end

    // Reset gates the request so it drops immediately, even mid-transfer.
    assign mem_req   = req_c & ~rst;
    assign mem_we    = we_c;
    assign mem_space = space_c;
    assign mem_addr  = addr_c;
    assign mem_wdata = wdata_c;
    assign inst      = inst_q;
    assign data      = data_q;
    assign operand   = opnd_q;
    assign dec_en    = exec_q;
    assign exec      = exec_q;
    assign pc        = pc_q;
    assign halted    = (state_q == FETCH_HI) & ~run & ~hold_q & ~rst;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer.
// Byte memory model with programmable ack delay; checks at mid-cycle.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b1;
    logic        mem_req, mem_we, mem_space, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [15:0] inst, operand, pc;
    logic [7:0]  data;
    logic        dec_en, exec, halted;
    logic [15:0] acc = 16'h0000;
    logic        acc_zero = 1'b0;
    logic        cond_flag = 1'b0;

    logic [7:0]  prog [256];
    logic [7:0]  ram [256];
    int          dly = 0;
    int          wcnt;
    int          total = 0;
    int          bad = 0;
    int          unstable = 0;
    int          wr_n = 0;
    int          w0;
    logic        wait_q = 1'b0;
    logic [15:0] addr_q = 16'h0;
    logic        we_q = 1'b0;
    logic        sp_q = 1'b0;
    logic [7:0]  wd_q = 8'h0;

    always #5 clk = ~clk;

    cpu_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_space(mem_space),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .inst(inst), .data(data), .operand(operand),
        .dec_en(dec_en), .exec(exec),
        .acc(acc), .acc_zero(acc_zero), .cond_flag(cond_flag),
        .pc(pc), .halted(halted)
    );

    assign mem_ack   = mem_req && (wcnt >= dly);
    assign mem_rdata = mem_space ? ram[mem_addr[7:0]]
                                 : prog[mem_addr[7:0]];

    always @(posedge clk or posedge rst) begin
        if (rst)
            wcnt <= 0;
        else if (mem_req && !mem_ack)
            wcnt <= wcnt + 1;
        else
            wcnt <= 0;
    end

    // Request attributes must not change while a transfer is pending.
    always @(negedge clk) begin
        if (!rst && wait_q && mem_req &&
            (mem_addr != addr_q || mem_we != we_q ||
             mem_space != sp_q || mem_wdata != wd_q))
            unstable = unstable + 1;
        if (!rst && mem_req && mem_ack && mem_we)
            wr_n = wr_n + 1;
        wait_q = mem_req && !mem_ack && !rst;
        addr_q = mem_addr;
        we_q   = mem_we;
        sp_q   = mem_space;
        wd_q   = mem_wdata;
    end

    task automatic chk(input string tag, input logic [15:0] o,
                       input logic [15:0] e);
        total = total + 1;
        assert (o === e) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        foreach (prog[i]) prog[i] = 8'h00;
        foreach (ram[i]) ram[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 16'(mem_req), 16'h0);
        chk("rst_we", 16'(mem_we), 16'h0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_inst", inst, 16'h0000);
        chk("rst_exec", 16'(exec), 16'h0);
        chk("rst_dec", 16'(dec_en), 16'h0);
        chk("rst_halt", 16'(halted), 16'h0);

        // T1: nop then load immediate, zero-wait
        prog[0] = 8'h00; prog[1] = 8'h00;
        prog[2] = 8'h80; prog[3] = 8'h2A;
        dly = 0; run = 1'b1;
        #1 rst = 1'b0;
        tick(1);
        chk("t1_c1_req", 16'(mem_req), 16'h1);
        chk("t1_c1_addr", mem_addr, 16'h0000);
        tick(1);
        chk("t1_c2_exec", 16'(exec), 16'h0);
        tick(1);
        chk("t1_c3_exec", 16'(exec), 16'h1);
        chk("t1_c3_inst", inst, 16'h0000);
        chk("t1_c3_req", 16'(mem_req), 16'h0);
        tick(1);
        chk("t1_c4_exec", 16'(exec), 16'h0);
        tick(2);
        chk("t1_c6_exec", 16'(exec), 16'h1);
        chk("t1_c6_inst", inst, 16'h802A);
        chk("t1_c6_pc", pc, 16'h0004);
        run = 1'b0;
        tick(1);
        chk("t1_halted", 16'(halted), 16'h1);
        chk("t1_halt_req", 16'(mem_req), 16'h0);
        chk("t1_halt_pc", pc, 16'h0004);

        // T2: inline data with two wait cycles per transfer
        prog[0] = 8'h82; prog[1] = 8'h00; prog[2] = 8'h5A;
        dly = 2; run = 1'b1;
        do_reset();
        tick(2);
        chk("t2_wait_ack", 16'(mem_ack), 16'h0);
        chk("t2_wait_addr", mem_addr, 16'h0000);
        tick(3);
        chk("t2_lo_addr", mem_addr, 16'h0001);
        tick(4);
        chk("t2_c9_exec", 16'(exec), 16'h0);
        tick(1);
        chk("t2_c10_exec", 16'(exec), 16'h1);
        chk("t2_data", 16'(data), 16'h005A);
        chk("t2_pc", pc, 16'h0003);
        run = 1'b0;
        tick(1);
        chk("t2_c11_exec", 16'(exec), 16'h0);
        chk("t2_stable", 16'(unstable), 16'h0);

        // T3: RAM operand
        prog[0] = 8'h84; prog[1] = 8'h10;
        ram[8'h10] = 8'h12; ram[8'h11] = 8'h34;
        dly = 0; run = 1'b1;
        do_reset();
        tick(3);
        chk("t3_rhi_addr", mem_addr, 16'h0010);
        chk("t3_rhi_sp", 16'(mem_space), 16'h1);
        chk("t3_rhi_we", 16'(mem_we), 16'h0);
        tick(1);
        chk("t3_rlo_addr", mem_addr, 16'h0011);
        chk("t3_rlo_sp", 16'(mem_space), 16'h1);
        tick(1);
        chk("t3_exec", 16'(exec), 16'h1);
        chk("t3_operand", operand, 16'h1234);
        chk("t3_pc", pc, 16'h0002);
        run = 1'b0;
        tick(1);

        // T4: store of acc
        prog[0] = 8'h94; prog[1] = 8'h10;
        acc = 16'hBEEF; run = 1'b1;
        w0 = wr_n;
        do_reset();
        tick(5);
        chk("t4_exec", 16'(exec), 16'h1);
        tick(1);
        chk("t4_shi_we", 16'(mem_we), 16'h1);
        chk("t4_shi_sp", 16'(mem_space), 16'h1);
        chk("t4_shi_addr", mem_addr, 16'h0010);
        chk("t4_shi_wd", 16'(mem_wdata), 16'h00BE);
        tick(1);
        chk("t4_slo_addr", mem_addr, 16'h0011);
        chk("t4_slo_wd", 16'(mem_wdata), 16'h00EF);
        chk("t4_slo_exec", 16'(exec), 16'h0);
        run = 1'b0;
        tick(1);
        chk("t4_writes", 16'(wr_n - w0), 16'h0002);
        chk("t4_back_fh", 16'(halted), 16'h1);
        chk("t4_pc", pc, 16'h0002);

        // T5a: false if skips the branch
        prog[0] = 8'hF0; prog[1] = 8'h00;
        prog[2] = 8'hC7; prog[3] = 8'hFE;
        acc_zero = 1'b0; run = 1'b1;
        do_reset();
        tick(3);
        chk("t5a_if_exec", 16'(exec), 16'h1);
        tick(3);
        chk("t5a_skip_dec", 16'(dec_en), 16'h0);
        chk("t5a_skip_exec", 16'(exec), 16'h0);
        run = 1'b0;
        tick(1);
        chk("t5a_pc", pc, 16'h0004);

        // T5b: true if, branch taken to 4 + (-2)
        acc_zero = 1'b1; run = 1'b1;
        do_reset();
        tick(6);
        chk("t5b_br_exec", 16'(exec), 16'h1);
        run = 1'b0;
        tick(1);
        chk("t5b_pc", pc, 16'h0002);

        // T5c: skipped RAM-operand instruction issues no RAM read
        prog[0] = 8'hF0; prog[1] = 8'h01;
        prog[2] = 8'h84; prog[3] = 8'h10;
        acc_zero = 1'b1; run = 1'b1;
        do_reset();
        tick(6);
        chk("t5c_req", 16'(mem_req), 16'h0);
        chk("t5c_dec", 16'(dec_en), 16'h0);
        chk("t5c_pc", pc, 16'h0004);
        run = 1'b0;
        tick(1);

        // T6: reset during RAM_HI, halt, then clean refetch
        prog[0] = 8'h84; prog[1] = 8'h10;
        ram[8'h10] = 8'h56; ram[8'h11] = 8'h78;
        dly = 2; run = 1'b1;
        do_reset();
        tick(7);
        chk("t6_rhi_req", 16'(mem_req), 16'h1);
        chk("t6_rhi_sp", 16'(mem_space), 16'h1);
        rst = 1'b1;
        #1;
        chk("t6_rst_req", 16'(mem_req), 16'h0);
        chk("t6_rst_pc", pc, 16'h0000);
        chk("t6_rst_inst", inst, 16'h0000);
        run = 1'b0; dly = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick(1);
        chk("t6_halted", 16'(halted), 16'h1);
        chk("t6_halt_req", 16'(mem_req), 16'h0);
        tick(1);
        chk("t6_halt_pc", pc, 16'h0000);
        run = 1'b1;
        #1;
        chk("t6_resume_addr", mem_addr, 16'h0000);
        tick(1);
        chk("t6_lo_pc", pc, 16'h0001);
        tick(1);
        chk("t6_ram_addr", mem_addr, 16'h0010);
        tick(2);
        chk("t6_exec", 16'(exec), 16'h1);
        chk("t6_operand", operand, 16'h5678);
        run = 1'b0;
        tick(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
